// File: rtl/pulse_pacer_if.sv
// Handshake bundle between an event source and pulse_pacer.
// master drives the event and control strobes; slave is the pacer.
interface pulse_pacer_if #(
  parameter int CNT_W = 4
);
  logic             event_in;
  logic             flush;
  logic             overflow_clr;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             idle;

  modport master (
    output event_in, flush, overflow_clr,
    input  pulse_out, pending, overflow, idle
  );

  modport slave (
    input  event_in, flush, overflow_clr,
    output pulse_out, pending, overflow, idle
  );
endinterface

// File: rtl/pulse_pacer.sv
// Queues incoming event pulses in a saturating counter and re-emits them
// as single-cycle pulses spaced at least GAP cycles apart.
module pulse_pacer #(
  parameter int GAP   = 9,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  pulse_pacer_if.slave bus
);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] MAX_PEND = {CNT_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  logic [CNT_W-1:0] pending_reg, pending_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             pulse_reg;
  logic             overflow_reg, overflow_next;

  logic ready;
  logic issue;
  logic full;
  logic accept;
  logic drop;

  assign ready  = (gap_cnt_reg == '0);
  assign full   = (pending_reg == MAX_PEND);
  assign issue  = ready && ((pending_reg != '0) || bus.event_in) && !bus.flush;
  assign accept = bus.event_in && !(full && !issue);
  // A flushed event is discarded silently, so it never counts as a drop.
  assign drop   = bus.event_in && full && !issue && !bus.flush;

  always_comb begin
    pending_next = pending_reg;
    if (bus.flush) begin
      pending_next = '0;
    end else begin
      unique case ({accept, issue})
        2'b10:   pending_next = pending_reg + 1'b1;
        2'b01:   pending_next = pending_reg - 1'b1;
        default: pending_next = pending_reg;
      endcase
    end
  end

  always_comb begin
    gap_cnt_next = gap_cnt_reg;
    if (issue) begin
      gap_cnt_next = GAP_LOAD;
    end else if (gap_cnt_reg != '0) begin
      gap_cnt_next = gap_cnt_reg - 1'b1;
    end
  end

  // Set has priority over clear so a drop is never hidden.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg  <= '0;
      gap_cnt_reg  <= '0;
      pulse_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      gap_cnt_reg  <= gap_cnt_next;
      pulse_reg    <= issue;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.pulse_out = pulse_reg;
  assign bus.pending   = pending_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.idle      = (pending_reg == '0) && (gap_cnt_reg == '0) && !pulse_reg;
endmodule
